comb_bench_seq_ctrl: RTL and testbench

- Sequencer and response compactor for the 8-input / 26-output combinational benchmark netlists.
- Drives every input pattern onto the netlist under test and waits a programmable settle time per pattern.
- Folds each 26-bit response into a multiple-input signature register (MISR) and reports a final signature with a start/busy/done handshake.
- Sits between a test host and one benchmark instance; one controller per netlist.

---
 rtl/comb_bench_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_comb_bench_seq_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comb_bench_seq_ctrl.sv
// rtl/comb_bench_seq_ctrl.sv - pattern sequencer and MISR response compactor for comb benchmark netlists
//
// Purpose: applies every input pattern (binary count or LFSR) to one netlist,
// waits SETTLE extra cycles per pattern, folds each response into a MISR and
// reports the final signature through a start/busy/done handshake.
//
// Ports:
//   clk        single clock, all state on rising edge
//   rst        synchronous active-high reset
//   start      begin a run (honoured in IDLE or DONE)
//   abort      stop a run in progress, signature/pat_count frozen
//   mode       0 = exhaustive binary count, 1 = LFSR (latched at start)
//   pat_out    pattern driven onto the netlist inputs
//   resp_in    netlist outputs
//   busy       high while applying/capturing
//   done       high while in DONE
//   signature  live MISR contents
//   pat_count  patterns captured so far
module comb_bench_seq_ctrl #(
    parameter int                IN_W      = 8,
    parameter int                OUT_W     = 26,
    parameter int                SETTLE    = 1,
    parameter logic [IN_W-1:0]   LFSR_SEED = 8'h01,
    parameter logic [IN_W-1:0]   LFSR_POLY = 8'hB8,
    parameter logic [OUT_W-1:0]  MISR_POLY = 26'h0000047
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    output logic [IN_W-1:0]   pat_out,
    input  logic [OUT_W-1:0]  resp_in,
    output logic              busy,
    output logic              done,
    output logic [OUT_W-1:0]  signature,
    output logic [IN_W:0]     pat_count
);

    // Settle counter is at least one bit wide so SETTLE=0 still elaborates.
    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE);

    // Run length: 2^IN_W in count mode, 2^IN_W-1 in LFSR mode (all-zero state excluded).
    localparam logic [IN_W:0] TOTAL_CNT  = {1'b1, {IN_W{1'b0}}};
    localparam logic [IN_W:0] LAST_CNT_0 = TOTAL_CNT - (IN_W+1)'(1);
    localparam logic [IN_W:0] LAST_CNT_1 = TOTAL_CNT - (IN_W+1)'(2);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_APPLY   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IN_W-1:0]    pat_q, pat_d;
    logic [OUT_W-1:0]   sig_q, sig_d;
    logic [IN_W:0]      cnt_q, cnt_d;
    logic [SW-1:0]      settle_q, settle_d;
    logic               mode_q, mode_d;

    logic               launch;
    logic [IN_W:0]      last_cnt;
    logic [IN_W-1:0]    pat_next;
    logic [OUT_W-1:0]   sig_fold;

    always_comb begin
        // A start in DONE together with abort is an abort, not a restart.
        launch   = start && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && !abort));
        last_cnt = mode_q ? LAST_CNT_1 : LAST_CNT_0;
        pat_next = mode_q ? {pat_q[IN_W-2:0], ^(pat_q & LFSR_POLY)}
                          : pat_q + IN_W'(1);
        sig_fold = {sig_q[OUT_W-2:0], 1'b0}
                 ^ (sig_q[OUT_W-1] ? MISR_POLY : {OUT_W{1'b0}})
                 ^ resp_in;
    end

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        sig_d    = sig_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        mode_d   = mode_q;

        if (launch) begin
            mode_d   = mode;
            pat_d    = mode ? LFSR_SEED : {IN_W{1'b0}};
            sig_d    = {OUT_W{1'b0}};
            cnt_d    = {(IN_W+1){1'b0}};
            settle_d = SETTLE_V;
            state_d  = ST_APPLY;
        end else begin
            case (state_q)
                ST_APPLY: begin
                    if (abort) begin
                        state_d = ST_IDLE;
                        pat_d   = {IN_W{1'b0}};
                    end else if (settle_q == '0) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        settle_d = settle_q - SW'(1);
                    end
                end
                ST_CAPTURE: begin
                    // Abort takes priority over the fold so the signature
                    // reflects only completed captures.
                    if (abort) begin
                        state_d = ST_IDLE;
                        pat_d   = {IN_W{1'b0}};
                    end else begin
                        sig_d = sig_fold;
                        cnt_d = cnt_q + (IN_W+1)'(1);
                        if (cnt_q == last_cnt) begin
                            state_d = ST_DONE;
                        end else begin
                            pat_d    = pat_next;
                            settle_d = SETTLE_V;
                            state_d  = ST_APPLY;
                        end
                    end
                end
                ST_DONE: begin
                    if (abort && start) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pat_q    <= {IN_W{1'b0}};
            sig_q    <= {OUT_W{1'b0}};
            cnt_q    <= {(IN_W+1){1'b0}};
            settle_q <= {SW{1'b0}};
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            sig_q    <= sig_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            mode_q   <= mode_d;
        end
    end

    assign pat_out   = pat_q;
    assign signature = sig_q;
    assign pat_count = cnt_q;
    assign busy      = (state_q == ST_APPLY) || (state_q == ST_CAPTURE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_comb_bench_seq_ctrl.sv
// tb/tb_comb_bench_seq_ctrl.sv - self-checking bench for comb_bench_seq_ctrl
module tb_comb_bench_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    // Instance 1: SETTLE=1
    logic        start1 = 1'b0, abort1 = 1'b0, mode1 = 1'b0;
    logic [7:0]  pat_out1;
    logic [25:0] resp_in1;
    logic        busy1, done1;
    logic [25:0] sig1;
    logic [8:0]  cnt1;

    // Instance 0: SETTLE=0, driven by the benchmark netlist
    logic        start0 = 1'b0, abort0 = 1'b0, mode0 = 1'b0;
    logic [7:0]  pat_out0;
    logic [25:0] resp_in0;
    logic        busy0, done0;
    logic [25:0] sig0;
    logic [8:0]  cnt0;

    logic        use_net1 = 1'b0;
    logic [25:0] resp_const1 = 26'h0;
    logic [25:0] key1 = 26'h0;
    logic [25:0] key0 = 26'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Stand-in 8-in/26-out combinational benchmark netlist, keyed per test.
    function automatic logic [25:0] net_fn(input logic [7:0] p, input logic [25:0] key);
        logic [7:0] a, b, c;
        a = p ^ key[7:0];
        b = p + key[15:8];
        c = (p & key[23:16]) | {p[0], p[7:1]};
        return {a, b, c, ^p, |(p & key[25:24])};
    endfunction

    function automatic logic [25:0] misr_fold(input logic [25:0] s, input logic [25:0] r);
        return {s[24:0], 1'b0} ^ (s[25] ? 26'h0000047 : 26'h0) ^ r;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] p);
        return {p[6:0], ^(p & 8'hB8)};
    endfunction

    // Signature after n captures, built straight from the pattern order and fold rule.
    function automatic logic [25:0] model_sig(input bit m, input int n, input bit use_net,
                                              input logic [25:0] cst, input logic [25:0] key);
        logic [7:0]  p;
        logic [25:0] s;
        p = m ? 8'h01 : 8'h00;
        s = 26'h0;
        for (int i = 0; i < n; i++) begin
            s = misr_fold(s, use_net ? net_fn(p, key) : cst);
            p = m ? lfsr_next(p) : p + 8'd1;
        end
        return s;
    endfunction

    assign resp_in1 = use_net1 ? net_fn(pat_out1, key1) : resp_const1;
    assign resp_in0 = net_fn(pat_out0, key0);

    comb_bench_seq_ctrl #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .mode(mode1),
        .pat_out(pat_out1), .resp_in(resp_in1), .busy(busy1), .done(done1),
        .signature(sig1), .pat_count(cnt1)
    );

    comb_bench_seq_ctrl #(.SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .mode(mode0),
        .pat_out(pat_out0), .resp_in(resp_in0), .busy(busy0), .done(done0),
        .signature(sig0), .pat_count(cnt0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on instance 1 and count edges until done (-1 on timeout).
    task automatic run1(input bit m, input bit poke_start, output int cycles, output int busy_low);
        mode1  = m;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        cycles   = 0;
        busy_low = 0;
        while (!done1 && cycles < 3000) begin
            if (!busy1) busy_low++;
            if (poke_start) start1 = 1'($urandom_range(0, 1));
            tick();
            cycles++;
        end
        start1 = 1'b0;
        if (!done1) cycles = -1;
    endtask

    task automatic wait_cnt1(input int n);
        int guard = 0;
        while (cnt1 != 9'(n) && guard < 3000) begin
            tick();
            guard++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy1, done1, pat_out1, sig1, cnt1} !== 45'h0) begin
            errors++;
            $display("FAIL reset busy=%0b done=%0b pat=%0h sig=%0h cnt=%0d required all 0",
                     busy1, done1, pat_out1, sig1, cnt1);
        end
    endtask

    task automatic test_exhaustive_zero();
        int cyc, bl;
        use_net1 = 1'b0;
        resp_const1 = 26'h0;
        run1(1'b0, 1'b0, cyc, bl);
        checks++;
        if (cyc !== 768) begin
            errors++;
            $display("FAIL exh_done_edge got %0d required 768", cyc);
        end
        checks++;
        if (bl !== 0) begin
            errors++;
            $display("FAIL exh_busy low %0d samples required 0", bl);
        end
        checks++;
        if (sig1 !== 26'h0 || cnt1 !== 9'd256) begin
            errors++;
            $display("FAIL exh_final sig=%0h cnt=%0d required 0 / 256", sig1, cnt1);
        end
    endtask

    task automatic test_misr_step();
        logic [25:0] exp_sig;
        use_net1 = 1'b0;
        resp_const1 = 26'h1;
        mode1  = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int j = 0; j <= 9; j++) begin
            if (j < 9) begin
                checks++;
                if (pat_out1 !== 8'(j / 3)) begin
                    errors++;
                    $display("FAIL misr_pat sample %0d got %0h required %0h", j, pat_out1, j / 3);
                end
            end
            if (j % 3 == 0 && j > 0) begin
                exp_sig = 26'((1 << (j / 3)) - 1);
                checks++;
                if (sig1 !== exp_sig || cnt1 !== 9'(j / 3)) begin
                    errors++;
                    $display("FAIL misr_sig sample %0d got %0h cnt %0d required %0h cnt %0d",
                             j, sig1, cnt1, exp_sig, j / 3);
                end
            end
            tick();
        end
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
    endtask

    task automatic test_lfsr();
        bit          seen [256];
        logic [7:0]  first [5];
        logic [7:0]  rec [$];
        logic [7:0]  p;
        logic [8:0]  prev;
        int          guard, dup, bad_seq;
        first = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
        use_net1 = 1'b1;
        key1 = 26'($urandom);
        mode1  = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        mode1  = 1'b0;             // mid-run mode change must not matter
        rec.push_back(pat_out1);
        prev  = cnt1;
        guard = 0;
        while (!done1 && guard < 3000) begin
            tick();
            guard++;
            if (cnt1 != prev && !done1) rec.push_back(pat_out1);
            prev = cnt1;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rec.size() <= i || rec[i] !== first[i]) begin
                errors++;
                $display("FAIL lfsr_first idx %0d got %0h required %0h", i,
                         (rec.size() > i) ? rec[i] : 8'hxx, first[i]);
            end
        end
        dup = 0;
        bad_seq = 0;
        p = 8'h01;
        foreach (rec[i]) begin
            if (seen[rec[i]]) dup++;
            seen[rec[i]] = 1'b1;
            if (rec[i] !== p) bad_seq++;
            p = lfsr_next(p);
        end
        checks++;
        if (rec.size() != 255 || dup != 0 || bad_seq != 0) begin
            errors++;
            $display("FAIL lfsr_unique patterns %0d dups %0d seq_err %0d required 255/0/0",
                     rec.size(), dup, bad_seq);
        end
        checks++;
        if (!done1 || cnt1 !== 9'd255 || sig1 !== model_sig(1'b1, 255, 1'b1, 26'h0, key1)) begin
            errors++;
            $display("FAIL lfsr_final done=%0b cnt=%0d sig=%0h required 1/255/%0h",
                     done1, cnt1, sig1, model_sig(1'b1, 255, 1'b1, 26'h0, key1));
        end
    endtask

    task automatic test_abort();
        logic [25:0] exp_sig;
        use_net1 = 1'b1;
        key1 = 26'($urandom);
        mode1  = 1'b0;
        start1 = 1'b1;              // restart from DONE
        tick();
        start1 = 1'b0;
        wait_cnt1(10);
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        exp_sig = model_sig(1'b0, 10, 1'b1, 26'h0, key1);
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || cnt1 !== 9'd10 || sig1 !== exp_sig || pat_out1 !== 8'h0) begin
            errors++;
            $display("FAIL abort busy=%0b done=%0b cnt=%0d sig=%0h pat=%0h required 0/0/10/%0h/0",
                     busy1, done1, cnt1, sig1, pat_out1, exp_sig);
        end
        tick();
        checks++;
        if (cnt1 !== 9'd10 || sig1 !== exp_sig) begin
            errors++;
            $display("FAIL abort_hold cnt=%0d sig=%0h required 10/%0h", cnt1, sig1, exp_sig);
        end
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checks++;
        if (sig1 !== 26'h0 || cnt1 !== 9'd0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart sig=%0h cnt=%0d busy=%0b required 0/0/1", sig1, cnt1, busy1);
        end
    endtask

    task automatic test_reset_midrun();
        wait_cnt1(5);
        tick();                      // inside APPLY of pattern 5
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy1, done1, pat_out1, sig1, cnt1} !== 45'h0) begin
            errors++;
            $display("FAIL reset_midrun busy=%0b done=%0b pat=%0h sig=%0h cnt=%0d required all 0",
                     busy1, done1, pat_out1, sig1, cnt1);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bl;
        use_net1 = 1'b1;
        key1 = 26'($urandom);
        run1(1'b0, 1'b1, cyc, bl);   // random start pulses while busy
        checks++;
        if (cyc !== 768 || cnt1 !== 9'd256 || sig1 !== model_sig(1'b0, 256, 1'b1, 26'h0, key1)) begin
            errors++;
            $display("FAIL start_ignored edges=%0d cnt=%0d sig=%0h required 768/256/%0h",
                     cyc, cnt1, sig1, model_sig(1'b0, 256, 1'b1, 26'h0, key1));
        end
        // abort alone in DONE does nothing
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        checks++;
        if (done1 !== 1'b1 || cnt1 !== 9'd256) begin
            errors++;
            $display("FAIL abort_in_done done=%0b cnt=%0d required 1/256", done1, cnt1);
        end
        // start held in DONE restarts; holding it while busy changes nothing
        start1 = 1'b1;
        tick();
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b1 || cnt1 !== 9'd0 || sig1 !== 26'h0) begin
            errors++;
            $display("FAIL restart_done done=%0b busy=%0b cnt=%0d sig=%0h required 0/1/0/0",
                     done1, busy1, cnt1, sig1);
        end
        for (int i = 0; i < 6; i++) tick();
        start1 = 1'b0;
        checks++;
        if (cnt1 !== 9'd2 || sig1 !== model_sig(1'b0, 2, 1'b1, 26'h0, key1)) begin
            errors++;
            $display("FAIL start_held cnt=%0d sig=%0h required 2/%0h",
                     cnt1, sig1, model_sig(1'b0, 2, 1'b1, 26'h0, key1));
        end
        wait_cnt1(256);
        tick();
        // abort together with start in DONE goes to IDLE
        abort1 = 1'b1;
        start1 = 1'b1;
        tick();
        abort1 = 1'b0;
        start1 = 1'b0;
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b0 || cnt1 !== 9'd256) begin
            errors++;
            $display("FAIL abort_start_done done=%0b busy=%0b cnt=%0d required 0/0/256",
                     done1, busy1, cnt1);
        end
    endtask

    task automatic test_golden();
        int cyc;
        key0   = 26'($urandom);
        mode0  = 1'b0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        cyc = 0;
        while (!done0 && cyc < 3000) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc !== 512) begin
            errors++;
            $display("FAIL golden_done_edge got %0d required 512", cyc);
        end
        checks++;
        if (sig0 !== model_sig(1'b0, 256, 1'b1, 26'h0, key0) || cnt0 !== 9'd256) begin
            errors++;
            $display("FAIL golden_sig got %0h cnt %0d required %0h cnt 256",
                     sig0, cnt0, model_sig(1'b0, 256, 1'b1, 26'h0, key0));
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_exhaustive_zero();
        test_misr_step();
        test_lfsr();
        test_abort();
        test_reset_midrun();
        test_back_to_back();
        test_golden();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
